// File: rtl/tri_inside.sv
// Three-edge inside-outside test of a plane hit point against one triangle.
// Vectors are packed {z, y, x}, x in the low D_WIDTH bits.
module tri_inside #(
    parameter int Q_BITS  = 16,
    parameter int D_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3*D_WIDTH-1:0]   v0,
    input  logic [3*D_WIDTH-1:0]   v1,
    input  logic [3*D_WIDTH-1:0]   v2,
    input  logic [3*D_WIDTH-1:0]   normal,
    input  logic [3*D_WIDTH-1:0]   in_p,
    input  logic                   in_empty,
    output logic                   in_rd_en,
    output logic [3*D_WIDTH-1:0]   out_p,
    output logic                   out_hit,
    input  logic                   out_full,
    output logic                   out_wr_en
);

    localparam int W2 = 2 * D_WIDTH;
    localparam int W3 = 3 * D_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        EDGE,
        WRITE
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]    k;
    logic          miss;
    logic [W3-1:0] p_q;
    logic [W3-1:0] v0_q;
    logic [W3-1:0] v1_q;
    logic [W3-1:0] v2_q;
    logic [W3-1:0] n_q;

    logic [W3-1:0] a;
    logic [W3-1:0] b;

    logic signed [D_WIDTH-1:0] d [3];
    logic signed [D_WIDTH-1:0] e [3];
    logic signed [D_WIDTH-1:0] c [3];
    logic signed [D_WIDTH-1:0] n [3];
    logic signed [W2+1:0]      s;
    logic                      neg;

    // One cross-product component: (a1*b1 - a2*b2) >>> Q, truncated.
    function automatic logic signed [D_WIDTH-1:0] xterm(
        input logic signed [D_WIDTH-1:0] a1,
        input logic signed [D_WIDTH-1:0] b1,
        input logic signed [D_WIDTH-1:0] a2,
        input logic signed [D_WIDTH-1:0] b2
    );
        logic signed [W2-1:0] m1;
        logic signed [W2-1:0] m2;
        logic signed [W2:0]   diff;
        m1   = W2'(a1) * W2'(b1);
        m2   = W2'(a2) * W2'(b2);
        diff = (W2+1)'(m1) - (W2+1)'(m2);
        diff = diff >>> Q_BITS;
        return diff[D_WIDTH-1:0];
    endfunction

    always_comb begin
        a = v0_q;
        b = v1_q;
        case (k)
            2'd1: begin
                a = v1_q;
                b = v2_q;
            end
            2'd2: begin
                a = v2_q;
                b = v0_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            d[i] = b[i*D_WIDTH +: D_WIDTH] - a[i*D_WIDTH +: D_WIDTH];
            e[i] = p_q[i*D_WIDTH +: D_WIDTH] - a[i*D_WIDTH +: D_WIDTH];
            n[i] = n_q[i*D_WIDTH +: D_WIDTH];
        end
        c[0] = xterm(d[1], e[2], d[2], e[1]);
        c[1] = xterm(d[2], e[0], d[0], e[2]);
        c[2] = xterm(d[0], e[1], d[1], e[0]);
        s = (W2+2)'(n[0]) * (W2+2)'(c[0])
          + (W2+2)'(n[1]) * (W2+2)'(c[1])
          + (W2+2)'(n[2]) * (W2+2)'(c[2]);
        neg = s[W2+1];
    end

    // Pop is suppressed while reset is held so nothing is lost upstream.
    always_comb begin
        state_next = state;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state)
            IDLE: begin
                in_rd_en = reset & ~in_empty;
                if (in_rd_en) begin
                    state_next = EDGE;
                end
            end
            EDGE: begin
                if (k == 2'd2) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                out_wr_en = ~out_full;
                if (out_wr_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k       <= 2'd0;
            miss    <= 1'b0;
            p_q     <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            n_q     <= '0;
            out_p   <= '0;
            out_hit <= 1'b0;
        end else if (in_rd_en) begin
            k    <= 2'd0;
            miss <= 1'b0;
            p_q  <= in_p;
            v0_q <= v0;
            v1_q <= v1;
            v2_q <= v2;
            n_q  <= normal;
        end else if (state == EDGE) begin
            k    <= (k == 2'd2) ? 2'd0 : k + 2'd1;
            miss <= miss | neg;
            if (k == 2'd2) begin
                out_p   <= p_q;
                out_hit <= ~(miss | neg);
            end
        end
    end

endmodule
